// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the write port of one byte FIFO between N burst requesters.
// Define FIFO_ARB_STATS_EN to build saturating per-requester accepted-beat counters on stat_beats.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic [8*N-1:0]  data,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    gnt,
  output logic [IDW-1:0]  cur_id,
  output logic            busy,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [7:0]      fifo_din,
  output logic [16*N-1:0] stat_beats
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int             IDW1        = IDW + 1;
  localparam logic [IDW-1:0] LAST_ID     = IDW'(N - 1);
  localparam logic [IDW:0]   N_V         = IDW1'(N);
  localparam logic [4:0]     MAX_BURST_V = 5'(MAX_BURST);
  localparam logic [N-1:0]   ONE_N       = N'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           busy_q, busy_d;
  logic [3:0]     beat_cnt_q, beat_cnt_d;

  logic [2*N-1:0] req_dbl_s;
  logic [N-1:0]   req_rot_s;
  logic [IDW:0]   sum_s;
  logic           any_req_s;
  logic [IDW-1:0] sel_s;
  logic           cur_req_s;
  logic           cur_last_s;
  logic [7:0]     cur_data_s;
  logic           accept_s;
  logic           burst_end_s;

  // Round-robin pick: rotate req so bit 0 is rr_ptr, then take the lowest set bit.
  always_comb begin
    req_dbl_s = {req, req} >> rr_ptr_q;
    req_rot_s = req_dbl_s[N-1:0];
    any_req_s = |req_rot_s;
    sel_s     = '0;
    sum_s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_s = {1'b0, rr_ptr_q} + IDW1'(k);
      sel_s = req_rot_s[k] ? ((sum_s >= N_V) ? IDW'(sum_s - N_V) : IDW'(sum_s)) : sel_s;
    end
  end

  // Select the granted requester's req/last/data.
  always_comb begin
    cur_req_s  = 1'b0;
    cur_last_s = 1'b0;
    cur_data_s = 8'h00;
    for (int i = 0; i < N; i++) begin
      cur_req_s  = (cur_id_q == IDW'(i)) ? req[i]         : cur_req_s;
      cur_last_s = (cur_id_q == IDW'(i)) ? last[i]        : cur_last_s;
      cur_data_s = (cur_id_q == IDW'(i)) ? data[8*i +: 8] : cur_data_s;
    end
  end

  // Beat acceptance and the FIFO write port; never write while the FIFO is full.
  always_comb begin
    accept_s = (state_q == BURST) && cur_req_s && !fifo_full;
    fifo_wr  = accept_s;
    fifo_din = cur_data_s;
    ack      = accept_s ? gnt_q : '0;
  end

  // Next-state logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cur_id_d    = cur_id_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d    = BURST;
          gnt_d      = ONE_N << sel_s;
          cur_id_d   = sel_s;
          busy_d     = 1'b1;
          beat_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        // A dropped req abandons the burst; a full FIFO simply holds everything.
        burst_end_s = !cur_req_s ||
                      (accept_s && (cur_last_s || (({1'b0, beat_cnt_q} + 5'd1) == MAX_BURST_V)));
        beat_cnt_d  = accept_s ? (beat_cnt_q + 4'd1) : beat_cnt_q;
        if (burst_end_s) begin
          state_d  = IDLE;
          gnt_d    = '0;
          busy_d   = 1'b0;
          cur_id_d = '0;
          rr_ptr_d = (cur_id_q == LAST_ID) ? '0 : (cur_id_q + IDW'(1));
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        busy_d     = 1'b0;
        cur_id_d   = '0;
        rr_ptr_d   = '0;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  // Grant FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      cur_id_q   <= '0;
      busy_q     <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cur_id_q   <= cur_id_d;
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign cur_id = cur_id_q;
  assign busy   = busy_q;

`ifdef FIFO_ARB_STATS_EN
  logic [16*N-1:0] stat_q, stat_d;

  // Saturating accepted-beat counters, one per requester.
  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < N; i++) begin
      stat_d[16*i +: 16] = (ack[i] && (stat_q[16*i +: 16] != 16'hFFFF)) ?
                           (stat_q[16*i +: 16] + 16'd1) : stat_q[16*i +: 16];
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_beats = stat_q;
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT, a monitor scores every FIFO write.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic [1:0]  cur_id;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic [63:0] stat_beats;

  logic [8:0]  src_q [4][$];
  logic [9:0]  exp_q [$];
  logic [3:0]  ack_s;
  int          n_chk;
  int          n_fail;

  fifo_wr_arbiter #(.N(4), .MAX_BURST(4), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .last       (last),
    .data       (data),
    .ack        (ack),
    .gnt        (gnt),
    .cur_id     (cur_id),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .stat_beats (stat_beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  // Expected grant per negedge, first entry in the top nibble of s.
  task automatic gnt_seq(input string nm, input logic [63:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] eg;
      logic [1:0] eid;
      @(negedge clk);
      eg  = s[60-4*k +: 4];
      eid = 2'd0;
      for (int j = 0; j < 4; j++) if (eg[j]) eid = 2'(j);
      chk($sformatf("%s gnt[%0d]", nm, k), 32'(gnt), 32'(eg));
      chk($sformatf("%s busy[%0d]", nm, k), 32'(busy), 32'(|eg));
      chk($sformatf("%s cur_id[%0d]", nm, k), 32'(cur_id), 32'(eid));
    end
  endtask

  // Requester model: present queue head, pop it once the beat was acked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ack_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req[i]         = 1'b1;
          last[i]        = src_q[i][0][8];
          data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req[i]  = 1'b0;
          last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: score every FIFO write against the expected queue.
  initial begin
    forever begin
      logic [9:0] e;
      @(negedge clk);
      ack_s = ack;
      if (fifo_wr) begin
        chk("wr_while_full", 32'(fifo_full), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({ack, fifo_din}), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_write", 32'({ack, fifo_din}), 32'({4'b0001 << e[9:8], e[7:0]}));
        end
      end else if (ack != 4'b0000) begin
        chk("ack_without_wr", 32'(ack), 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] b;
    n_chk = 0;
    n_fail = 0;
    ack_s = 4'b0000;
    rst = 1'b1;
    req = 4'b0000;
    last = 4'b0000;
    data = 32'h0;
    fifo_full = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(gnt), 32'd0);
    chk("rst cur_id", 32'(cur_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst stat", 32'(stat_beats[31:0] | stat_beats[63:32]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // single requester, three-beat burst
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    exp_push(2'd0, 8'h11);
    exp_push(2'd0, 8'h22);
    exp_push(2'd0, 8'h33);
    gnt_seq("single", 64'h0111_0000_0000_0000, 5);

    // rr_ptr is now 1: requester 1 wins over 0
    src_q[0].push_back({1'b1, 8'hA0});
    src_q[1].push_back({1'b1, 8'hB1});
    exp_push(2'd1, 8'hB1);
    exp_push(2'd0, 8'hA0);
    gnt_seq("rr_ptr", 64'h0201_0000_0000_0000, 5);

    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // fairness: all four requesting, one-beat bursts, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'h40 + 8'(16 * i) + 8'(r);
        src_q[i].push_back({1'b1, b});
        exp_push(2'(i), b);
      end
    end
    gnt_seq("fair", 64'h0102_0408_0102_0408, 16);
    @(negedge clk);
    chk("fair end gnt", 32'(gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef FIFO_ARB_STATS_EN
      chk($sformatf("stat[%0d]", i), 32'(stat_beats[16*i +: 16]), 32'd2);
`else
      chk($sformatf("stat[%0d]", i), 32'(stat_beats[16*i +: 16]), 32'd0);
`endif
    end

    // forced rotation after four beats, then abandon when the queue runs dry
    for (int k = 0; k < 5; k++) begin
      b = 8'h50 + 8'(k);
      src_q[2].push_back({1'b0, b});
      exp_push(2'd2, b);
    end
    gnt_seq("forced", 64'h0444_4044_0000_0000, 9);

    // abandon after one beat without last
    src_q[3].push_back({1'b0, 8'h6A});
    exp_push(2'd3, 8'h6A);
    gnt_seq("abandon", 64'h0880_0000_0000_0000, 4);

    // full stall in the middle of a burst from requester 1
    for (int k = 0; k < 4; k++) begin
      b = 8'h71 + 8'(k);
      src_q[1].push_back({(k == 3), b});
      exp_push(2'd1, b);
    end
    gnt_seq("stall pre", 64'h0200_0000_0000_0000, 2);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall ack[%0d]", k), 32'(ack), 32'd0);
      chk($sformatf("stall wr[%0d]", k), 32'(fifo_wr), 32'd0);
      chk($sformatf("stall gnt[%0d]", k), 32'(gnt), 32'h2);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    gnt_seq("stall post", 64'h2220_0000_0000_0000, 4);

    // reset mid-burst: grant cleared, next arbitration starts from 0
    src_q[2].push_back({1'b0, 8'h81});
    src_q[2].push_back({1'b0, 8'h82});
    src_q[2].push_back({1'b0, 8'h83});
    exp_push(2'd2, 8'h81);
    exp_push(2'd2, 8'h82);
    gnt_seq("midrst pre", 64'h0400_0000_0000_0000, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    src_q[1].push_back({1'b1, 8'h91});
    exp_push(2'd1, 8'h91);
    exp_push(2'd2, 8'h83);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst gnt", 32'(gnt), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst cur_id", 32'(cur_id), 32'd0);
    gnt_seq("midrst post", 64'h2044_0000_0000_0000, 5);

    @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the write port of one 8-entry byte FIFO between N requesters.
- Grants one requester at a time for a burst of beats and forwards its data to the FIFO write port.
- Stalls the granted requester while the FIFO reports full.
- Sits directly in front of the FIFO; the FIFO read side is not touched.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum accepted beats per grant before forced rotation (1..15).
- IDW, 2, width of cur_id; must be at least ceil(log2(N)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester beat valid.
- last  in  N  per-requester end-of-burst marker, qualified by req.
- data  in  8*N  per-requester byte; requester i uses bits [8i+7:8i].
- ack  out  N  combinational beat-accepted strobe, one-hot or zero.
- gnt  out  N  registered one-hot grant.
- cur_id  out  IDW  registered index of the granted requester; 0 when idle.
- busy  out  1  registered; high while in state BURST.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  combinational FIFO write strobe.
- fifo_din  out  8  combinational FIFO write data.
- stat_beats  out  16*N  per-requester accepted-beat counters (see Optional Feature).

Behaviour:
- Reset values: gnt=0, cur_id=0, busy=0, state=IDLE, rr_ptr=0, beat_cnt=0, stat_beats=0.
- Combinational outputs follow their equations during reset. With gnt=0 this gives ack=0 and fifo_wr=0.
- rst has priority over every other event.
- State IDLE:
  - No grant is held.
  - If any req bit is high, select the first high bit searching upward from rr_ptr, wrapping modulo N.
  - Next edge: gnt=onehot(sel), cur_id=sel, busy=1, beat_cnt=0, state goes to BURST.
  - Arbitration latency: 1 cycle from req to gnt.
- State BURST, beat acceptance:
  - A beat is accepted when req[cur_id]=1 and fifo_full=0.
  - In the same cycle: ack[cur_id]=1, fifo_wr=1, fifo_din=data[cur_id].
  - Otherwise ack=0, fifo_wr=0, and fifo_din=data[cur_id] (a don't-care value).
  - Each accepted beat increments beat_cnt (4-bit).
- State BURST, end conditions (any one, evaluated at the edge):
  - (a) An accepted beat with last[cur_id]=1.
  - (b) An accepted beat where beat_cnt+1 == MAX_BURST.
  - (c) req[cur_id]=0, which abandons the burst with no beat that cycle.
- Burst end, next edge: gnt=0, busy=0, cur_id=0, rr_ptr=(cur_id+1) mod N, state goes to IDLE.
  - Every grant is followed by at least one IDLE cycle.
- fifo_full=1 in BURST:
  - No accept and no end condition; gnt is held indefinitely.
  - The requester must keep req high to retain the grant.
- Requesters other than cur_id are ignored in BURST; their ack stays 0.
- req and last of non-granted requesters may change freely.
- fifo_wr is never asserted while fifo_full=1, so the FIFO never sees a write it would drop.
- Reset mid-burst: grant is cleared at that edge. Beats already written stay in the FIFO, and rr_ptr returns to 0.
- An IDLE cycle with req=0 holds all state.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined:
  - Each requester has a 16-bit counter in stat_beats[16i+15:16i].
  - The counter increments on every accepted beat for that requester and saturates at 0xFFFF.
  - rst clears all counters.
- When not defined:
  - No counter registers are built.
  - stat_beats is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Single requester: rst, then req[0]=1 with data 0x11,0x22,0x33 and last on the 3rd beat, fifo_full=0. Expect gnt[0] one cycle after req, three consecutive fifo_wr pulses with fifo_din 0x11/0x22/0x33, gnt=0 after the third beat, rr_ptr=1.
- Fairness: req=4'b1111 held, last=1 on every beat. Expect grant order 0,1,2,3,0, each grant one beat followed by one idle cycle.
- Forced rotation: req[2]=1 held, last=0, MAX_BURST=4. Expect exactly 4 writes, gnt drops, next grant goes to req[2] again (only requester) after one idle cycle.
- Full stall: granted requester 1, fifo_full=1 for 5 cycles mid-burst. Expect ack=0 and fifo_wr=0 for those 5 cycles, gnt[1] held; after fifo_full=0 the remaining beats are written in order with none lost.
- Abandon and reset: req[3] drops after 1 beat without last, so gnt clears on the next edge. Separately, rst asserted mid-burst gives gnt=0, busy=0 at that edge and the next arbitration starts from requester 0.
- Stats (FIFO_ARB_STATS_EN defined): after the fairness test runs for 8 grants, stat_beats reads 2 for each requester. Without the macro, stat_beats is 0.
